// File: rtl/saturated_signed_divider_pkg.sv
// Shared types and helpers for the saturated signed divider: FSM state
// encoding and two's-complement limits for an arbitrary result width.
package saturated_signed_divider_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Largest value representable in a signed field of width w.
    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Most negative value representable in a signed field of width w.
    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/saturated_signed_divider_step.sv
// One combinational restoring-division step on unsigned magnitudes:
// shift the next dividend bit into the remainder, subtract the divisor if it fits.
module unsigned_div_step #(
    parameter int BS = 8
) (
    input  logic [BS:0]   rem_i,
    input  logic [BS-1:0] dvs_i,
    input  logic          bit_i,
    output logic [BS:0]   rem_o,
    output logic          q_o
);

    logic [BS+1:0] shifted;
    logic [BS+1:0] diff;

    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = shifted - (BS+2)'(dvs_i);
        q_o     = (shifted >= (BS+2)'(dvs_i));
        // The kept remainder is always below the divisor, so BS+1 bits suffice.
        rem_o   = (BS+1)'(q_o ? diff : shifted);
    end

endmodule

// File: rtl/saturated_signed_divider.sv
// Multi-cycle signed fixed-point divider: out = trunc((a << OFFSET) / b),
// saturated to OUTS bits, with a fixed W+1 cycle latency from accept to result.
module saturated_signed_divider
    import saturated_signed_divider_pkg::*;
#(
    parameter int AS     = 16,
    parameter int BS     = 8,
    parameter int OFFSET = 8,
    parameter int OUTS   = AS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AS-1:0]   a,
    input  logic [BS-1:0]   b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OUTS-1:0] out,
    output logic            sat,
    output logic            dbz
);

    localparam int W  = AS + OFFSET;
    localparam int CW = $clog2(W);
    localparam logic [OUTS-1:0] OUT_MAX = OUTS'(sat_max(OUTS));
    localparam logic [OUTS-1:0] OUT_MIN = OUTS'(sat_min(OUTS));

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            fin_q, fin_d;
    logic [W-1:0]    dq_q, dq_d;      // dividend shifts out MSB-first, quotient shifts in LSB
    logic [BS:0]     rem_q, rem_d;
    logic [BS-1:0]   dvs_q, dvs_d;
    logic            neg_q, neg_d;
    logic            a_neg_q, a_neg_d;
    logic            zero_q, zero_d;
    logic [OUTS-1:0] out_q, out_d;
    logic            sat_q, sat_d;
    logic            dbz_q, dbz_d;

    logic [BS:0]         step_rem;
    logic                step_q;
    logic [AS:0]         a_ext, a_mag;
    logic [BS:0]         b_ext, b_mag;
    logic signed [63:0]  mag_l, val;

    unsigned_div_step #(.BS(BS)) u_step (
        .rem_i (rem_q),
        .dvs_i (dvs_q),
        .bit_i (dq_q[W-1]),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        fin_d   = fin_q;
        dq_d    = dq_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        neg_d   = neg_q;
        a_neg_d = a_neg_q;
        zero_d  = zero_q;
        out_d   = out_q;
        sat_d   = sat_q;
        dbz_d   = dbz_q;

        // One extra bit keeps the magnitude of the most negative operand exact.
        a_ext = {a[AS-1], a};
        a_mag = a_ext[AS] ? -a_ext : a_ext;
        b_ext = {b[BS-1], b};
        b_mag = b_ext[BS] ? -b_ext : b_ext;
        mag_l = 64'(dq_q);
        val   = neg_q ? -mag_l : mag_l;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_CALC;
                    a_neg_d = a[AS-1];
                    neg_d   = a[AS-1] ^ b[BS-1];
                    zero_d  = (b == '0);
                    dq_d    = W'({a_mag, {OFFSET{1'b0}}});
                    dvs_d   = BS'(b_mag);
                    rem_d   = '0;
                    cnt_d   = CW'(W - 1);
                    fin_d   = 1'b0;
                end
            end
            S_CALC: begin
                if (!fin_q) begin
                    dq_d  = {dq_q[W-2:0], step_q};
                    rem_d = step_rem;
                    if (cnt_q == '0) fin_d = 1'b1;
                    else             cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = S_DONE;
                    fin_d   = 1'b0;
                    dbz_d   = zero_q;
                    if (zero_q) begin
                        out_d = a_neg_q ? OUT_MIN : OUT_MAX;
                        sat_d = 1'b1;
                    end else if (val > sat_max(OUTS)) begin
                        out_d = OUT_MAX;
                        sat_d = 1'b1;
                    end else if (val < sat_min(OUTS)) begin
                        out_d = OUT_MIN;
                        sat_d = 1'b1;
                    end else begin
                        out_d = OUTS'(val);
                        sat_d = 1'b0;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            fin_q   <= 1'b0;
            dq_q    <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            neg_q   <= 1'b0;
            a_neg_q <= 1'b0;
            zero_q  <= 1'b0;
            out_q   <= '0;
            sat_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fin_q   <= fin_d;
            dq_q    <= dq_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            neg_q   <= neg_d;
            a_neg_q <= a_neg_d;
            zero_q  <= zero_d;
            out_q   <= out_d;
            sat_q   <= sat_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out       = out_q;
    assign sat       = sat_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_saturated_signed_divider.sv
// Directed-vector bench for saturated_signed_divider at default parameters;
// expected quotients, flags and latency are hand-computed constants.
module tb_saturated_signed_divider;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic        sat;
    logic        dbz;

    int n_vec = 0;
    int n_err = 0;

    saturated_signed_divider dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .sat       (sat),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Apply one operand pair, check latency and result; optionally hold
    // out_ready low for 'hold' cycles while poking in_valid, then handshake.
    task automatic run(input string tag, input logic [15:0] va, input logic [7:0] vb,
                       input logic [15:0] eq, input logic es, input logic ez, input int hold);
        int lat;
        @(negedge clk);
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd25);
        check({tag, " out"}, 32'(out), 32'(eq));
        check({tag, " sat"}, 32'(sat), 32'(es));
        check({tag, " dbz"}, 32'(dbz), 32'(ez));
        if (hold > 0) begin
            in_valid = 1'b1;
            a        = 16'd1;
            b        = 8'd1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                check({tag, " hold result"}, {13'd0, sat, dbz, out_valid, out}, {13'd0, es, ez, 1'b1, eq});
                check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " released out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " released in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int stale;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #2;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out", 32'(out), 32'd0);
        check("reset flags", {30'd0, sat, dbz}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run("300/4",       16'd300,          8'd4,          16'h4B00, 1'b0, 1'b0, 0);
        run("-1/3",        -16'sd1,          8'd3,          16'hFFAB, 1'b0, 1'b0, 0);
        run("-7/2",        -16'sd7,          8'd2,          16'hFC80, 1'b0, 1'b0, 0);
        run("100/-3",      16'd100,          -8'sd3,        16'hDEAB, 1'b0, 1'b0, 0);
        run("256/2",       16'd256,          8'd2,          16'h7FFF, 1'b1, 1'b0, 0);
        run("-256/2",      -16'sd256,        8'd2,          16'h8000, 1'b0, 1'b0, 0);
        run("-256/1",      -16'sd256,        8'd1,          16'h8000, 1'b1, 1'b0, 0);
        run("min/min",     16'h8000,         8'h80,         16'h7FFF, 1'b1, 1'b0, 0);
        run("5/0",         16'd5,            8'd0,          16'h7FFF, 1'b1, 1'b1, 0);
        run("-5/0",        -16'sd5,          8'd0,          16'h8000, 1'b1, 1'b1, 0);
        run("0/0",         16'd0,            8'd0,          16'h7FFF, 1'b1, 1'b1, 0);
        run("backpressure", -16'sd7,         8'd2,          16'hFC80, 1'b0, 1'b0, 10);

        // Abort an operation 10 cycles into CALC with an asynchronous reset.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 16'd300;
        b        = 8'd4;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort out", 32'(out), 32'd0);
        check("abort in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort released in_ready", 32'(in_ready), 32'd1);
        stale = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) stale++;
        end
        check("abort no stale result", 32'(stale), 32'd0);

        run("after abort", 16'd300, 8'd4, 16'h4B00, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
